mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Execute-stage memory/register sequencer downstream of the instruction fetcher. Accepts decoded
//  opcode + effective address/immediate on instruction_ready; performs load, store or
//  read-modify-write cycles. Writes A/X/Y and N/Z/C flags, then pulses instruction_done so the
//  fetcher starts the next fetch.
// PARAMETERS
//  ADDR_WIDTH  16  address bus width
//  REG_WIDTH   8   data/register width
// PORTS
//  phi2               in   1           clock; all state changes on posedge
//  reset_n            in   1           reset, synchronous, active-low
//  instruction_ready  in   1           opcode/ea/imm valid; level, held until instruction_done
//  opcode             in   REG_WIDTH   instruction byte
//  ea                 in   ADDR_WIDTH  effective address from fetcher
//  imm                in   REG_WIDTH   immediate operand
//  a_in/x_in/y_in     in   REG_WIDTH   current register values
//  carry_in           in   1           current C flag
//  mem_rdata          in   REG_WIDTH   read data, valid the cycle after mem_re
//  mem_addr           out  ADDR_WIDTH  memory address
//  mem_wdata          out  REG_WIDTH   write data
//  mem_re / mem_we    out  1           read / write strobe
//  reg_sel            out  2           write target: 0=A 1=X 2=Y
//  reg_wdata, reg_we  out  REG_WIDTH,1 register write-back
//  flag_n/z/c, flag_we out 1 each      flag update, flag_c valid for RMW shifts only
//  instruction_done   out  1           one-cycle completion pulse
//  busy, unsup        out  1           op in progress / last op unsupported
// BEHAVIOUR
//  - All outputs registered; reset_n=0 at an edge -> state IDLE, every output 0 (unsup included).
//  - Decode by cc=op[1:0], aaa=op[7:5], bbb=op[4:2]: aaa=101 load, aaa=100 store (cc 01=A,10=X,00=Y);
//    immediate load if (cc=01,bbb=010) or (cc!=01,bbb=000); cc=10, bbb in {001,011,101,111},
//    aaa in {000 ASL,001 ROL,010 LSR,011 ROR,110 DEC,111 INC} = RMW; anything else = UNSUP.
//  - Accept: IDLE and instruction_ready=1 -> latch opcode/ea/imm, busy=1. Cycle N = N edges later.
//  - States: IDLE, READ, WB, WRITE, MOD, RMW_WR, DONE_HOLD.
//  - LOAD: c1 READ mem_re=1 mem_addr=ea; c2 WB reg_wdata=mem_rdata, reg_we, flag_we(N,Z), done.
//  - IMM: c1 WB from imm, reg_we, flag_we, done. No memory strobe.
//  - STORE: c1 WRITE mem_we=1, mem_addr=ea, mem_wdata=selected reg, done. No flag_we.
//  - RMW: c1 READ; c2 MOD latch/compute; c3 RMW_WR mem_we with result, flag_we(N,Z,C), done.
//    ASL/LSR shift in 0; ROL/ROR shift in carry_in; C=bit shifted out; INC/DEC wrap mod 2^REG_WIDTH,
//    C unchanged (flag_c=carry_in).
//  - UNSUP: c1 done=1, unsup=1; no strobes. unsup holds until next accept.
//  - done pulse -> DONE_HOLD for exactly one cycle, instruction_ready ignored -> IDLE; busy clears
//    entering IDLE. Strobes/reg_we/flag_we are one-cycle pulses.
//  - instruction_ready while busy: ignored; inputs re-latched only on accept.
//  - Reset mid-op: pending write/write-back abandoned, no done pulse, IDLE next cycle.
//  - mem_addr holds last value when no strobe; ea used unmodified (no page/zero-page wrap here).
// CONFIGURATION
//  MAU_DUMMY_WRITE_EN defined: RMW MOD cycle also asserts mem_we at ea with unmodified read
//   value (6502 double write); latency unchanged.
//  Undefined: MOD cycle has no memory strobe.
// TESTING
//  LDA abs: op=AD ea=1234 rdata=80 -> c1 re@1234; c2 A=80 N=1 Z=0 done.
//  LDX imm: op=A2 imm=00 -> c1 X=00 Z=1 N=0 done, no re/we.
//  STA: op=8D ea=0200 a_in=55 -> c1 we@0200 wdata=55 done, no flag_we.
//  INC zpg: op=E6 ea=0010 rdata=FF -> c3 we wdata=00 Z=1 N=0; ROR op=6E carry_in=1 rdata=01 -> 80 C=1 N=1.
//  Reset in RMW c2 -> no mem_we, no done, busy=0 next cycle; ready held after done -> no re-accept for 1 cycle.
//  op=EA -> c1 done unsup=1, no strobes; with MAU_DUMMY_WRITE_EN, INC c2 we wdata=FF.

Source files
------------

// File: rtl/mem_access_unit.sv
// Execute-stage memory/register sequencer: load, immediate load, store and read-modify-write.
// Optional MAU_DUMMY_WRITE_EN: RMW MOD cycle rewrites the unmodified value (6502 double write).
module mem_access_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 8
) (
  input  logic                  phi2,
  input  logic                  reset_n,
  input  logic                  instruction_ready,
  input  logic [REG_WIDTH-1:0]  opcode,
  input  logic [ADDR_WIDTH-1:0] ea,
  input  logic [REG_WIDTH-1:0]  imm,
  input  logic [REG_WIDTH-1:0]  a_in,
  input  logic [REG_WIDTH-1:0]  x_in,
  input  logic [REG_WIDTH-1:0]  y_in,
  input  logic                  carry_in,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [1:0]            reg_sel,
  output logic [REG_WIDTH-1:0]  reg_wdata,
  output logic                  reg_we,
  output logic                  flag_n,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  flag_we,
  output logic                  instruction_done,
  output logic                  busy,
  output logic                  unsup
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WB, S_WRITE, S_MOD, S_RMW_WR, S_DONE_HOLD
  } state_t;

  typedef enum logic [2:0] {K_LOAD, K_IMM, K_STORE, K_RMW, K_UNSUP} kind_t;

  function automatic kind_t decode(input logic [7:0] op);
    logic [1:0] cc;
    logic [2:0] aaa, bbb;
    cc  = op[1:0];
    aaa = op[7:5];
    bbb = op[4:2];
    if (aaa == 3'b101 && cc != 2'b11) begin
      if ((cc == 2'b01 && bbb == 3'b010) || (cc != 2'b01 && bbb == 3'b000)) return K_IMM;
      return K_LOAD;
    end
    if (aaa == 3'b100 && cc != 2'b11) return K_STORE;
    // aaa 100/101 already taken above, so every remaining aaa is a legal RMW op
    if (cc == 2'b10 && bbb[0]) return K_RMW;
    return K_UNSUP;
  endfunction

  function automatic logic [1:0] cc_to_sel(input logic [1:0] cc);
    case (cc)
      2'b01:   return 2'd0;
      2'b10:   return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // {carry_out, result}
  function automatic logic [REG_WIDTH:0] rmw_calc(input logic [2:0] aaa,
                                                  input logic [REG_WIDTH-1:0] v,
                                                  input logic cin);
    logic [REG_WIDTH-1:0] one;
    one = {{(REG_WIDTH-1){1'b0}}, 1'b1};
    case (aaa)
      3'b000:  return {v, 1'b0};
      3'b001:  return {v, cin};
      3'b010:  return {v[0], 1'b0, v[REG_WIDTH-1:1]};
      3'b011:  return {v[0], cin, v[REG_WIDTH-1:1]};
      3'b110:  return {cin, v - one};
      3'b111:  return {cin, v + one};
      default: return {cin, v};
    endcase
  endfunction

  state_t                state, state_nx;
  kind_t                 kind_q, kind_nx;
  logic [2:0]            aaa_q, aaa_nx;
  logic [ADDR_WIDTH-1:0] ea_q, ea_nx;
  logic [1:0]            sel_q, sel_nx;
  logic [REG_WIDTH-1:0]  data_q, data_nx;

  logic [ADDR_WIDTH-1:0] mem_addr_nx;
  logic [REG_WIDTH-1:0]  mem_wdata_nx, reg_wdata_nx;
  logic [1:0]            reg_sel_nx;
  logic                  mem_re_nx, mem_we_nx, reg_we_nx;
  logic                  flag_n_nx, flag_z_nx, flag_c_nx, flag_we_nx;
  logic                  done_nx, busy_nx, unsup_nx;

  kind_t                 kind_in;
  logic [1:0]            sel_in;
  logic [REG_WIDTH-1:0]  store_val;
  logic [REG_WIDTH:0]    rmw;

  assign kind_in = decode(opcode[7:0]);
  assign sel_in  = cc_to_sel(opcode[1:0]);
  assign rmw     = rmw_calc(aaa_q, data_q, carry_in);

  always_comb begin
    case (sel_in)
      2'd0:    store_val = a_in;
      2'd1:    store_val = x_in;
      default: store_val = y_in;
    endcase
  end

  always_comb begin
    state_nx     = state;
    kind_nx      = kind_q;
    aaa_nx       = aaa_q;
    ea_nx        = ea_q;
    sel_nx       = sel_q;
    data_nx      = data_q;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    mem_re_nx    = 1'b0;
    mem_we_nx    = 1'b0;
    reg_sel_nx   = reg_sel;
    reg_wdata_nx = reg_wdata;
    reg_we_nx    = 1'b0;
    flag_n_nx    = flag_n;
    flag_z_nx    = flag_z;
    flag_c_nx    = flag_c;
    flag_we_nx   = 1'b0;
    done_nx      = 1'b0;
    busy_nx      = busy;
    unsup_nx     = unsup;
    case (state)
      S_IDLE: begin
        if (instruction_ready) begin
          kind_nx  = kind_in;
          aaa_nx   = opcode[7:5];
          ea_nx    = ea;
          sel_nx   = sel_in;
          busy_nx  = 1'b1;
          unsup_nx = 1'b0;
          case (kind_in)
            K_LOAD, K_RMW: begin
              state_nx    = S_READ;
              mem_re_nx   = 1'b1;
              mem_addr_nx = ea;
            end
            K_IMM: begin
              state_nx     = S_WB;
              reg_we_nx    = 1'b1;
              reg_sel_nx   = sel_in;
              reg_wdata_nx = imm;
              flag_n_nx    = imm[REG_WIDTH-1];
              flag_z_nx    = (imm == '0);
              flag_c_nx    = carry_in;
              flag_we_nx   = 1'b1;
              done_nx      = 1'b1;
            end
            K_STORE: begin
              state_nx     = S_WRITE;
              mem_we_nx    = 1'b1;
              mem_addr_nx  = ea;
              mem_wdata_nx = store_val;
              done_nx      = 1'b1;
            end
            default: begin
              // unsupported ops reuse WB as their single completion cycle
              state_nx = S_WB;
              unsup_nx = 1'b1;
              done_nx  = 1'b1;
            end
          endcase
        end
      end
      S_READ: begin
        if (kind_q == K_RMW) begin
          state_nx = S_MOD;
          data_nx  = mem_rdata;
`ifdef MAU_DUMMY_WRITE_EN
          mem_we_nx    = 1'b1;
          mem_addr_nx  = ea_q;
          mem_wdata_nx = mem_rdata;
`endif
        end else begin
          state_nx     = S_WB;
          reg_we_nx    = 1'b1;
          reg_sel_nx   = sel_q;
          reg_wdata_nx = mem_rdata;
          flag_n_nx    = mem_rdata[REG_WIDTH-1];
          flag_z_nx    = (mem_rdata == '0);
          flag_c_nx    = carry_in;
          flag_we_nx   = 1'b1;
          done_nx      = 1'b1;
        end
      end
      S_MOD: begin
        state_nx     = S_RMW_WR;
        mem_we_nx    = 1'b1;
        mem_addr_nx  = ea_q;
        mem_wdata_nx = rmw[REG_WIDTH-1:0];
        flag_n_nx    = rmw[REG_WIDTH-1];
        flag_z_nx    = (rmw[REG_WIDTH-1:0] == '0);
        flag_c_nx    = rmw[REG_WIDTH];
        flag_we_nx   = 1'b1;
        done_nx      = 1'b1;
      end
      S_WB, S_WRITE, S_RMW_WR: state_nx = S_DONE_HOLD;
      S_DONE_HOLD: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge phi2) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      kind_q           <= K_LOAD;
      aaa_q            <= '0;
      ea_q             <= '0;
      sel_q            <= '0;
      data_q           <= '0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      mem_re           <= 1'b0;
      mem_we           <= 1'b0;
      reg_sel          <= '0;
      reg_wdata        <= '0;
      reg_we           <= 1'b0;
      flag_n           <= 1'b0;
      flag_z           <= 1'b0;
      flag_c           <= 1'b0;
      flag_we          <= 1'b0;
      instruction_done <= 1'b0;
      busy             <= 1'b0;
      unsup            <= 1'b0;
    end else begin
      state            <= state_nx;
      kind_q           <= kind_nx;
      aaa_q            <= aaa_nx;
      ea_q             <= ea_nx;
      sel_q            <= sel_nx;
      data_q           <= data_nx;
      mem_addr         <= mem_addr_nx;
      mem_wdata        <= mem_wdata_nx;
      mem_re           <= mem_re_nx;
      mem_we           <= mem_we_nx;
      reg_sel          <= reg_sel_nx;
      reg_wdata        <= reg_wdata_nx;
      reg_we           <= reg_we_nx;
      flag_n           <= flag_n_nx;
      flag_z           <= flag_z_nx;
      flag_c           <= flag_c_nx;
      flag_we          <= flag_we_nx;
      instruction_done <= done_nx;
      busy             <= busy_nx;
      unsup            <= unsup_nx;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed ops, a per-cycle expectation queue built from opcode
// rules, and one negedge compare process.
module tb_mem_access_unit;

  logic        phi2 = 1'b0;
  logic        reset_n = 1'b0;
  logic        instruction_ready = 1'b0;
  logic [7:0]  opcode = '0, imm = '0, a_in = '0, x_in = '0, y_in = '0, mem_rdata = '0;
  logic [15:0] ea = '0;
  logic        carry_in = 1'b0;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, reg_wdata;
  logic        mem_re, mem_we, reg_we, flag_n, flag_z, flag_c, flag_we;
  logic [1:0]  reg_sel;
  logic        instruction_done, busy, unsup;

  mem_access_unit #(.ADDR_WIDTH(16), .REG_WIDTH(8)) dut (
    .phi2(phi2), .reset_n(reset_n), .instruction_ready(instruction_ready),
    .opcode(opcode), .ea(ea), .imm(imm), .a_in(a_in), .x_in(x_in), .y_in(y_in),
    .carry_in(carry_in), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .reg_sel(reg_sel), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_we(flag_we),
    .instruction_done(instruction_done), .busy(busy), .unsup(unsup)
  );

  always #5 phi2 = ~phi2;

  typedef struct {
    logic        re, we, reg_we, flag_we, done, busy, unsup;
    logic [15:0] addr;
    logic [7:0]  wdata, rdat, lit;
    logic [1:0]  sel;
    logic        n, z, c, chk_c, lit_ok;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic chk_en = 1'b0;
  logic model_unsup = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  function automatic exp_t blank(input logic b, input logic u);
    exp_t e;
    e = '{default: '0};
    e.busy  = b;
    e.unsup = u;
    return e;
  endfunction

  // 0 load, 1 immediate, 2 store, 3 rmw, 4 unsupported
  function automatic int kind_of(input int op);
    int aaa, bbb, cc;
    aaa = op / 32;
    bbb = (op / 4) % 8;
    cc  = op % 4;
    if (cc == 3) return 4;
    if (aaa == 5) return ((cc == 1 && bbb == 2) || (cc != 1 && bbb == 0)) ? 1 : 0;
    if (aaa == 4) return 2;
    if (cc == 2 && (bbb % 2) == 1) return 3;
    return 4;
  endfunction

  function automatic void rmw_model(input int aaa, input int v, input int cin,
                                    output int res, output int c);
    case (aaa)
      0:       begin res = (v * 2) % 256;       c = v / 128; end
      1:       begin res = (v * 2 + cin) % 256; c = v / 128; end
      2:       begin res = v / 2;               c = v % 2;   end
      3:       begin res = v / 2 + cin * 128;   c = v % 2;   end
      6:       begin res = (v + 255) % 256;     c = cin;     end
      default: begin res = (v + 1) % 256;      c = cin;     end
    endcase
  endfunction

  always @(negedge phi2) begin : cmp
    exp_t e;
    if (chk_en) begin
      if (q.size() > 0) e = q.pop_front();
      else e = blank(1'b0, model_unsup);
      chk("mem_re", mem_re, e.re);
      chk("mem_we", mem_we, e.we);
      chk("reg_we", reg_we, e.reg_we);
      chk("flag_we", flag_we, e.flag_we);
      chk("done", instruction_done, e.done);
      chk("busy", busy, e.busy);
      chk("unsup", unsup, e.unsup);
      if (e.re || e.we) chk("mem_addr", mem_addr, e.addr);
      if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
      if (e.reg_we) begin
        chk("reg_sel", reg_sel, e.sel);
        chk("reg_wdata", reg_wdata, e.rdat);
      end
      if (e.flag_we) begin
        chk("flag_n", flag_n, e.n);
        chk("flag_z", flag_z, e.z);
      end
      if (e.chk_c) chk("flag_c", flag_c, e.c);
      if (e.lit_ok) chk("literal", e.we ? mem_wdata : reg_wdata, e.lit);
    end
  end

  // Called at a negedge; returns at the negedge of the op's first idle cycle.
  task automatic issue(input int op, input logic [15:0] ad, input logic [7:0] im,
                       input logic [7:0] rd, input logic [7:0] av, input logic [7:0] xv,
                       input logic [7:0] yv, input logic cin, input logic lit_ok,
                       input logic [7:0] lit, input logic keep);
    int k, cc, nrec, done_k, res, c;
    logic u;
    exp_t e;
    k  = kind_of(op);
    cc = op % 4;
    u  = (k == 4);
    opcode = 8'(op); ea = ad; imm = im; mem_rdata = rd;
    a_in = av; x_in = xv; y_in = yv; carry_in = cin;
    instruction_ready = 1'b1;
    @(posedge phi2);
    #1;
    nrec = 0;
    done_k = 1;
    if (k == 0 || k == 3) begin
      e = blank(1'b1, 1'b0); e.re = 1'b1; e.addr = ad;
      q.push_back(e); nrec++;
    end
    if (k == 3) begin
      e = blank(1'b1, 1'b0);
`ifdef MAU_DUMMY_WRITE_EN
      e.we = 1'b1; e.addr = ad; e.wdata = rd;
`endif
      q.push_back(e); nrec++;
      rmw_model(op / 32, rd, cin, res, c);
      e = blank(1'b1, 1'b0);
      e.we = 1'b1; e.addr = ad; e.wdata = 8'(res);
      e.flag_we = 1'b1; e.n = (res >= 128); e.z = (res == 0); e.chk_c = 1'b1; e.c = c[0];
    end else begin
      e = blank(1'b1, u);
      if (k == 0 || k == 1) begin
        e.reg_we = 1'b1;
        e.sel = (cc == 1) ? 2'd0 : (cc == 2) ? 2'd1 : 2'd2;
        e.rdat = (k == 0) ? rd : im;
        e.flag_we = 1'b1; e.n = (e.rdat >= 128); e.z = (e.rdat == 0);
      end else if (k == 2) begin
        e.we = 1'b1; e.addr = ad;
        e.wdata = (cc == 1) ? av : (cc == 2) ? xv : yv;
      end
    end
    e.done = 1'b1; e.lit_ok = lit_ok; e.lit = lit;
    q.push_back(e); nrec++;
    done_k = nrec;
    q.push_back(blank(1'b1, u)); nrec++;   // hold cycle: ready must be ignored
    q.push_back(blank(1'b0, u)); nrec++;   // back in idle
    model_unsup = u;
    repeat (done_k) @(negedge phi2);
    if (!keep) instruction_ready = 1'b0;
    repeat (nrec - done_k) @(negedge phi2);
  endtask

  task automatic reset_mid_rmw();
    exp_t e;
    opcode = 8'hE6; ea = 16'h0040; mem_rdata = 8'h12; carry_in = 1'b0;
    instruction_ready = 1'b1;
    @(posedge phi2);
    #1;
    e = blank(1'b1, 1'b0); e.re = 1'b1; e.addr = 16'h0040;
    q.push_back(e);
    e = blank(1'b1, 1'b0);
`ifdef MAU_DUMMY_WRITE_EN
    e.we = 1'b1; e.addr = 16'h0040; e.wdata = 8'h12;
`endif
    q.push_back(e);
    q.push_back(blank(1'b0, 1'b0));   // reset took effect: nothing left pending
    model_unsup = 1'b0;
    @(negedge phi2);
    @(negedge phi2);
    reset_n = 1'b0;
    instruction_ready = 1'b0;
    @(negedge phi2);
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge phi2);
    #1 chk_en = 1'b1;
    repeat (2) @(negedge phi2);
    reset_n = 1'b1;
    @(negedge phi2);
    //     op     ea        imm    rdata  a      x      y      cin   lit?  lit    keep
    issue(8'hAD, 16'h1234, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0); // LDA abs
    issue(8'hA2, 16'h0000, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0); // LDX imm
    issue(8'h8D, 16'h0200, 8'h00, 8'h00, 8'h55, 8'h11, 8'h22, 1'b0, 1'b1, 8'h55, 1'b0); // STA
    issue(8'hE6, 16'h0010, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0); // INC zpg
    issue(8'h6E, 16'h0300, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h80, 1'b0); // ROR abs
    issue(8'hEA, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); // NOP unsup
    issue(8'hAC, 16'h4000, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h7F, 1'b0); // LDY abs
    issue(8'h8E, 16'hFFFF, 8'h00, 8'h00, 8'h11, 8'hAA, 8'h22, 1'b0, 1'b1, 8'hAA, 1'b0); // STX top addr
    issue(8'h8C, 16'h0000, 8'h00, 8'h00, 8'h11, 8'h22, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0); // STY addr 0
    issue(8'h0A, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); // ASL A unsup
    issue(8'h06, 16'h0020, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0); // ASL zpg
    issue(8'h2E, 16'h1000, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0); // ROL abs
    issue(8'h4E, 16'h1001, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0); // LSR abs
    issue(8'hD6, 16'h0050, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0); // DEC zpg,X
    issue(8'hFF, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); // cc=11 unsup
    issue(8'hA9, 16'h0000, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0); // LDA imm
    issue(8'hA2, 16'h0000, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h7F, 1'b1); // ready held
    issue(8'hA2, 16'h0000, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h7F, 1'b0);
    reset_mid_rmw();
    repeat (3) @(negedge phi2);
    issue(8'hB5, 16'h0077, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0); // LDA zpg,X
    repeat (2) @(negedge phi2);
    chk_en = 1'b0;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
